// File: rtl/bp_mem_scratchpad.sv
// bp_mem_scratchpad: single-outstanding memory-command scratchpad backed by a
// 64-bit wide single-port synchronous SRAM. Single-beat requests access one
// word with byte granularity; block requests stream eight words in ascending order.
module bp_mem_scratchpad #(
  parameter int paddr_width_p  = 40,
  parameter int block_width_p  = 512,
  parameter int lce_id_width_p = 1,
  parameter int els_p          = 1024
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic [1:0]                mem_cmd_type_i,
  input  logic [paddr_width_p-1:0]  mem_cmd_addr_i,
  input  logic [2:0]                mem_cmd_size_i,
  input  logic [lce_id_width_p-1:0] mem_cmd_lce_id_i,
  input  logic [block_width_p-1:0]  mem_cmd_data_i,
  input  logic                      mem_cmd_v_i,
  output logic                      mem_cmd_ready_o,

  output logic [1:0]                mem_resp_type_o,
  output logic [paddr_width_p-1:0]  mem_resp_addr_o,
  output logic [2:0]                mem_resp_size_o,
  output logic [lce_id_width_p-1:0] mem_resp_lce_id_o,
  output logic [block_width_p-1:0]  mem_resp_data_o,
  output logic                      mem_resp_v_o,
  input  logic                      mem_resp_yumi_i
);

  localparam int lg_els_lp = $clog2(els_p);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WAIT, S_RESP} state_e;

  state_e state_r, state_n;

  logic                      ready_en_r;
  logic [2:0]                beat_r;
  logic [1:0]                type_r;
  logic [paddr_width_p-1:0]  addr_r;
  logic [2:0]                size_r;
  logic [lce_id_width_p-1:0] lce_id_r;
  logic [block_width_p-1:0]  wdata_r;
  logic [block_width_p-1:0]  resp_data_r;

  logic                      cmd_fire;
  logic                      sram_v;
  logic                      is_block;
  logic                      is_write;
  logic [2:0]                last_beat;
  logic [2:0]                offset;
  logic [3:0]                single_bytes;
  logic [lg_els_lp-1:0]      word_base;
  logic [lg_els_lp-1:0]      sram_addr;
  logic [63:0]               sram_wdata;
  logic [7:0]                sram_wmask;
  logic [7:0]                byte_en;
  logic [63:0]               read_shifted;
  logic [63:0]               read_single;

  logic [63:0]               mem_r [els_p];
  logic [63:0]               rdata_r;
  logic                      rd_v_r;
  logic [2:0]                rd_beat_r;

  assign cmd_fire          = mem_cmd_ready_o & mem_cmd_v_i;
  assign mem_resp_type_o   = type_r;
  assign mem_resp_addr_o   = addr_r;
  assign mem_resp_size_o   = size_r;
  assign mem_resp_lce_id_o = lce_id_r;
  assign mem_resp_data_o   = resp_data_r;

  // State register; reset abandons whatever request is in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= S_IDLE;
    else            state_r <= state_n;
  end

  // Next-state: accept in IDLE, stream beats in BUSY, one WAIT for the last read, hold RESP until yumi.
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE:  if (cmd_fire) state_n = S_BUSY;
      S_BUSY:  if (beat_r == last_beat) state_n = S_WAIT;
      S_WAIT:  state_n = S_RESP;
      S_RESP:  if (mem_resp_yumi_i) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State-decoded handshakes and SRAM enable; ready is held off until the first edge after reset.
  always_comb begin
    mem_cmd_ready_o = 1'b0;
    mem_resp_v_o    = 1'b0;
    sram_v          = 1'b0;
    case (state_r)
      S_IDLE:  mem_cmd_ready_o = ready_en_r;
      S_BUSY:  sram_v          = 1'b1;
      S_RESP:  mem_resp_v_o    = 1'b1;
      default: ;
    endcase
  end

  // Ready enable comes up one edge after reset is released.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ready_en_r <= 1'b0;
    else            ready_en_r <= 1'b1;
  end

  // Beat counter walks 0..last_beat while BUSY and sits at zero otherwise.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)             beat_r <= 3'd0;
    else if (state_r == S_BUSY) beat_r <= (beat_r == last_beat) ? 3'd0 : beat_r + 3'd1;
    else                        beat_r <= 3'd0;
  end

  // Latch the accepted command; these registers also drive the echoed response fields.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      type_r   <= '0;
      addr_r   <= '0;
      size_r   <= '0;
      lce_id_r <= '0;
      wdata_r  <= '0;
    end else if (cmd_fire) begin
      type_r   <= mem_cmd_type_i;
      addr_r   <= mem_cmd_addr_i;
      size_r   <= mem_cmd_size_i;
      lce_id_r <= mem_cmd_lce_id_i;
      wdata_r  <= mem_cmd_data_i;
    end
  end

  // Decode size, word index, write lanes/data and the aligned, size-masked single-beat read.
  always_comb begin
    is_block  = size_r[2] & size_r[1];
    is_write  = type_r[0];
    last_beat = is_block ? 3'd7 : 3'd0;
    offset    = addr_r[2:0];
    word_base = addr_r[3 +: lg_els_lp];
    sram_addr = is_block ? {word_base[lg_els_lp-1:3], beat_r} : word_base;
    case (size_r)
      3'd0:    single_bytes = 4'd1;
      3'd1:    single_bytes = 4'd2;
      3'd2:    single_bytes = 4'd4;
      default: single_bytes = 4'd8;
    endcase
    byte_en      = '0;
    read_single  = '0;
    read_shifted = rdata_r >> {offset, 3'b000};
    for (int b = 0; b < 8; b++) begin
      byte_en[b] = (4'(b) >= {1'b0, offset}) && ((4'(b) - {1'b0, offset}) < single_bytes);
      if (4'(b) < single_bytes) read_single[8*b +: 8] = read_shifted[8*b +: 8];
    end
    sram_wdata = is_block ? wdata_r[64*beat_r +: 64] : (wdata_r[63:0] << {offset, 3'b000});
    sram_wmask = is_block ? 8'hFF : byte_en;
  end

  // Single-port SRAM: one byte-masked write or one synchronous read per BUSY cycle; never reset.
  always_ff @(posedge clk_i) begin
    if (sram_v && is_write) begin
      for (int b = 0; b < 8; b++) begin
        if (sram_wmask[b]) mem_r[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
    if (sram_v && !is_write) rdata_r <= mem_r[sram_addr];
  end

  // Track which beat's read data appears on rdata_r in the following cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_v_r    <= 1'b0;
      rd_beat_r <= 3'd0;
    end else begin
      rd_v_r    <= sram_v & ~is_write;
      rd_beat_r <= beat_r;
    end
  end

  // Assemble response data: cleared on accept so writes answer zero, filled as read words return.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_data_r <= '0;
    end else if (cmd_fire) begin
      resp_data_r <= '0;
    end else if (rd_v_r) begin
      if (is_block) resp_data_r[64*rd_beat_r +: 64] <= rdata_r;
      else          resp_data_r[63:0]               <= read_single;
    end
  end

endmodule

// File: doc/bp_mem_scratchpad.md
BP_MEM_SCRATCHPAD -- requirements
Module: bp_mem_scratchpad

Interface
REQ-001 SHALL have parameter paddr_width_p, default 40, meaning physical address width.
REQ-002 SHALL have parameter block_width_p, default 512, meaning command/response data width (one cache block).
REQ-003 SHALL have parameter lce_id_width_p, default 1, meaning requester id width.
REQ-004 SHALL have parameter els_p, default 1024, meaning number of 64-bit storage words (power of two).
REQ-005 SHALL have ports: clk_i in 1, the single clock; reset_n_i in 1, reset, asynchronous and active-low.
REQ-006 SHALL have command ports: mem_cmd_type_i in 2 (0 rd, 1 wr, 2 uc_rd, 3 uc_wr); mem_cmd_addr_i in paddr_width_p; mem_cmd_size_i in 3 (log2 bytes); mem_cmd_lce_id_i in lce_id_width_p; mem_cmd_data_i in block_width_p.
REQ-007 SHALL have command handshake ports: mem_cmd_v_i in 1 (command valid); mem_cmd_ready_o out 1 (ready-valid, transfer when both high).
REQ-008 SHALL have response ports: mem_resp_type_o out 2, mem_resp_addr_o out paddr_width_p, mem_resp_size_o out 3, mem_resp_lce_id_o out lce_id_width_p, mem_resp_data_o out block_width_p.
REQ-009 SHALL have response handshake ports: mem_resp_v_o out 1 (response valid); mem_resp_yumi_i in 1 (consumer takes response, valid-yumi).

Function
REQ-010 SHALL implement FSM IDLE -> BUSY -> WAIT -> RESP -> IDLE, with one request outstanding at most.
REQ-011 SHALL assert mem_cmd_ready_o only in IDLE, and SHALL latch type, addr, size, lce_id and data on acceptance (cycle T).
REQ-012 SHALL set beats=8 for size 6 (block), and SHALL set beats=1 for sizes 0-3; sizes 4,5 SHALL act as size 3, and size 7 SHALL act as size 6.
REQ-013 SHALL make word index = addr[3 +: log2(els_p)] with upper address bits ignored (aliasing); block requests SHALL ignore addr[5:0] and access words base..base+7 in ascending order.
REQ-014 SHALL, in BUSY, perform one single-port synchronous SRAM access per cycle for beats cycles (counter 0..beats-1), then go to WAIT for one cycle to capture the final read data.
REQ-015 SHALL have a fixed latency: mem_resp_v_o first high at T+beats+2 (T+3 single, T+10 block).
REQ-016 SHALL, for a single-beat write, write byte lanes offset=addr[2:0] through min(offset+2^size-1, 7) with mem_cmd_data_i[63:0] shifted left by 8*offset; bytes beyond lane 7 SHALL be dropped.
REQ-017 SHALL, for a block write, write beat k with data[64k +: 64] and all byte lanes enabled.
REQ-018 SHALL, for a single-beat read, return the word shifted right by 8*offset and zero-extended above 2^size bytes in mem_resp_data_o[63:0], with all higher bits zero.
REQ-019 SHALL, for a block read, place word k in mem_resp_data_o[64k +: 64].
REQ-020 SHALL echo the latched type, addr, size and lce_id on the response, and write responses SHALL carry all-zero data.
REQ-021 SHALL hold all response outputs stable in RESP until mem_resp_yumi_i, then return to IDLE; mem_cmd_ready_o SHALL rise the cycle after yumi (one bubble).
REQ-022 SHALL ignore mem_resp_yumi_i while mem_resp_v_o is low, and SHALL ignore mem_cmd_v_i outside IDLE.
REQ-023 SHALL treat uc_rd/uc_wr identically to rd/wr.

Reset
REQ-024 SHALL, while reset_n_i is low, force state to IDLE, beat counter to 0, mem_cmd_ready_o=0, mem_resp_v_o=0, and all response fields to 0, regardless of clock.
REQ-025 SHALL set mem_cmd_ready_o=1 on the first clock edge after reset_n_i rises.
REQ-026 SHALL, on reset mid-operation, abandon the in-flight request with no response; SRAM contents SHALL NOT be reset, and completed writes SHALL persist.

Verification
REQ-027 SHALL cover block write then read: wr size6 addr 0x8000_0040 data words k=0x1111_1111_1111_1111*k -> wr resp at T+10; a subsequent rd size6 at the same addr returns identical 512 bits at T'+10.
REQ-028 SHALL cover partial write: word 0 = 0xFFFF_FFFF_FFFF_FFFF, wr size1 addr 0x...03 data 0xABCD -> word 0 = 0xFFFF_FFAB_CDFF_FFFF; rd size2 addr 0x...04 returns 0x0000_0000_FFFF_FFAB.
REQ-029 SHALL cover lane truncation: wr size3 addr offset 6 data 0x0102_0304_0506_0708 -> only bytes 6,7 become 0x08,0x07; the word at index+1 is unchanged.
REQ-030 SHALL cover back-pressure: hold mem_resp_yumi_i low 5 cycles -> mem_resp_v_o and all fields stable, mem_cmd_ready_o low; yumi pulse -> ready high next cycle.
REQ-031 SHALL cover reset mid-block: assert reset_n_i low at T+4 of a block write -> outputs zero immediately, no response; beats 0-2 written, beats 3-7 unchanged.
REQ-032 SHALL cover aliasing: with els_p=1024, wr to addr 0x2000 and rd from addr 0x0 -> the read returns the written data.
